// File: rtl/prco_mem_ctrl.sv
// prco_mem_ctrl
// Arbitrates one shared single-port memory between an instruction-fetch port
// and a load/store port. Each port holds one pending request. The data port
// has priority. Every access runs through a three-state FSM (IDLE/FETCH/DATA).
// An access that receives no completion strobe within P_TIMEOUT cycles is
// aborted. It then acks with zero data and pulses q_err.
//
// Ports
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_if_req, i_if_addr         fetch request strobe + address
//   q_if_ack, q_if_instr        fetch done pulse + fetched word (held)
//   i_ls_req, i_ls_we,
//   i_ls_addr, i_ls_wdata       load/store request strobe + fields
//   q_ls_ack, q_ls_rdata        load/store done pulse + load data (held)
//   q_ce_fetch, q_ce_alu        one-cycle memory enables (fetch / data)
//   q_mem_we, q_mem_addr,
//   q_mem_dina                  memory write enable, address, write data
//   i_ce_dec, i_ce_reg          memory completion strobes (fetch / data)
//   i_mem_douta                 memory read data, valid with a strobe
//   q_busy                      FSM not in IDLE
//   q_err                       timeout pulse, coincident with the ack
module prco_mem_ctrl #(
    parameter int P_TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_if_req,
    input  logic [15:0] i_if_addr,
    output logic        q_if_ack,
    output logic [15:0] q_if_instr,
    input  logic        i_ls_req,
    input  logic        i_ls_we,
    input  logic [15:0] i_ls_addr,
    input  logic [15:0] i_ls_wdata,
    output logic        q_ls_ack,
    output logic [15:0] q_ls_rdata,
    output logic        q_ce_fetch,
    output logic        q_ce_alu,
    output logic        q_mem_we,
    output logic [15:0] q_mem_addr,
    output logic [15:0] q_mem_dina,
    input  logic        i_ce_dec,
    input  logic        i_ce_reg,
    input  logic [15:0] i_mem_douta,
    output logic        q_busy,
    output logic        q_err
);

    localparam int CW = (P_TIMEOUT < 1) ? 1 : $clog2(P_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LIMIT = CW'(P_TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t          state_r;
    logic            f_pend_r;
    logic [15:0]     f_addr_r;
    logic            d_pend_r;
    logic            d_we_r;
    logic [15:0]     d_addr_r;
    logic [15:0]     d_wdata_r;
    logic [CW-1:0]   cnt_r;

    // A strobe is only captured when its port has no request outstanding.
    logic            f_take_s;
    logic            d_take_s;
    // In IDLE, a strobe arriving this cycle is issued at once. This is how
    // the ce reaches the memory one cycle after the request.
    logic            f_any_s;
    logic            d_any_s;
    logic [15:0]     f_addr_s;
    logic            d_we_s;
    logic [15:0]     d_addr_s;
    logic [15:0]     d_wdata_s;

    assign f_take_s  = i_if_req & ~f_pend_r;
    assign d_take_s  = i_ls_req & ~d_pend_r;
    assign f_any_s   = f_pend_r | i_if_req;
    assign d_any_s   = d_pend_r | i_ls_req;
    assign f_addr_s  = f_pend_r ? f_addr_r  : i_if_addr;
    assign d_we_s    = d_pend_r ? d_we_r    : i_ls_we;
    assign d_addr_s  = d_pend_r ? d_addr_r  : i_ls_addr;
    assign d_wdata_s = d_pend_r ? d_wdata_r : i_ls_wdata;

    // Request latching, arbitration FSM, timeout counter and all outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r    <= IDLE;
            f_pend_r   <= 1'b0;
            f_addr_r   <= 16'h0000;
            d_pend_r   <= 1'b0;
            d_we_r     <= 1'b0;
            d_addr_r   <= 16'h0000;
            d_wdata_r  <= 16'h0000;
            cnt_r      <= {CW{1'b0}};
            q_if_ack   <= 1'b0;
            q_if_instr <= 16'h0000;
            q_ls_ack   <= 1'b0;
            q_ls_rdata <= 16'h0000;
            q_ce_fetch <= 1'b0;
            q_ce_alu   <= 1'b0;
            q_mem_we   <= 1'b0;
            q_mem_addr <= 16'h0000;
            q_mem_dina <= 16'h0000;
            q_busy     <= 1'b0;
            q_err      <= 1'b0;
        end else begin
            q_ce_fetch <= 1'b0;
            q_ce_alu   <= 1'b0;
            q_mem_we   <= 1'b0;
            q_if_ack   <= 1'b0;
            q_ls_ack   <= 1'b0;
            q_err      <= 1'b0;

            if (f_take_s) begin
                f_pend_r <= 1'b1;
                f_addr_r <= i_if_addr;
            end
            if (d_take_s) begin
                d_pend_r  <= 1'b1;
                d_we_r    <= i_ls_we;
                d_addr_r  <= i_ls_addr;
                d_wdata_r <= i_ls_wdata;
            end

            case (state_r)
                IDLE: begin
                    cnt_r <= {CW{1'b0}};
                    if (d_any_s) begin
                        q_ce_alu   <= 1'b1;
                        q_mem_we   <= d_we_s;
                        q_mem_addr <= d_addr_s;
                        q_mem_dina <= d_wdata_s;
                        q_busy     <= 1'b1;
                        state_r    <= DATA;
                    end else if (f_any_s) begin
                        q_ce_fetch <= 1'b1;
                        q_mem_addr <= f_addr_s;
                        q_busy     <= 1'b1;
                        state_r    <= FETCH;
                    end else begin
                        q_busy     <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                FETCH: begin
                    // A strobe in the limit cycle still completes normally.
                    if (i_ce_dec) begin
                        q_if_instr <= i_mem_douta;
                        q_if_ack   <= 1'b1;
                        f_pend_r   <= 1'b0;
                        q_busy     <= 1'b0;
                        state_r    <= IDLE;
                    end else if (cnt_r == TMO_LIMIT) begin
                        q_if_instr <= 16'h0000;
                        q_if_ack   <= 1'b1;
                        q_err      <= 1'b1;
                        f_pend_r   <= 1'b0;
                        q_busy     <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        cnt_r      <= cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (i_ce_reg) begin
                        if (!d_we_r) begin
                            q_ls_rdata <= i_mem_douta;
                        end
                        q_ls_ack   <= 1'b1;
                        d_pend_r   <= 1'b0;
                        q_busy     <= 1'b0;
                        state_r    <= IDLE;
                    end else if (cnt_r == TMO_LIMIT) begin
                        q_ls_rdata <= 16'h0000;
                        q_ls_ack   <= 1'b1;
                        q_err      <= 1'b1;
                        d_pend_r   <= 1'b0;
                        q_busy     <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        cnt_r      <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    q_busy  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prco_mem_ctrl.sv
// Bench for prco_mem_ctrl. A transaction-level model tracks the outstanding
// request per port and the single access in flight. It predicts each ce,
// ack and error cycle from the issue cycle plus the memory latency the bench
// chooses. The bench itself acts as the memory, using the model's view of
// which access is in flight.
module tb_prco_mem_ctrl;

    localparam int P = 15;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_if_req;
    logic [15:0] i_if_addr;
    logic        q_if_ack;
    logic [15:0] q_if_instr;
    logic        i_ls_req;
    logic        i_ls_we;
    logic [15:0] i_ls_addr;
    logic [15:0] i_ls_wdata;
    logic        q_ls_ack;
    logic [15:0] q_ls_rdata;
    logic        q_ce_fetch;
    logic        q_ce_alu;
    logic        q_mem_we;
    logic [15:0] q_mem_addr;
    logic [15:0] q_mem_dina;
    logic        i_ce_dec;
    logic        i_ce_reg;
    logic [15:0] i_mem_douta;
    logic        q_busy;
    logic        q_err;

    prco_mem_ctrl #(.P_TIMEOUT(P)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .q_if_ack(q_if_ack), .q_if_instr(q_if_instr),
        .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
        .i_ls_wdata(i_ls_wdata), .q_ls_ack(q_ls_ack), .q_ls_rdata(q_ls_rdata),
        .q_ce_fetch(q_ce_fetch), .q_ce_alu(q_ce_alu), .q_mem_we(q_mem_we),
        .q_mem_addr(q_mem_addr), .q_mem_dina(q_mem_dina),
        .i_ce_dec(i_ce_dec), .i_ce_reg(i_ce_reg), .i_mem_douta(i_mem_douta),
        .q_busy(q_busy), .q_err(q_err)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mvalid = 1'b0;

    // model: outstanding requests, access in flight, memory contents
    bit          occ_f, occ_d, d_we, tmo;
    logic [15:0] f_addr, d_addr, d_wdata;
    int          act = 0;        // 0 none, 1 fetch, 2 data
    int          ce_at, ack_at, act_lat;
    int          lat = 1;        // memory latency in cycles after ce; 0 = never
    logic [15:0] mem [int];

    // expected outputs for the current cycle
    bit          e_ce_f, e_ce_d, e_we, e_iack, e_lack, e_err, e_busy;
    logic [15:0] e_addr, e_dina, e_instr, e_rdata;

    // observed event cycles
    int last_cef = -100, last_ced = -100, last_iack = -100, last_lack = -100;
    int last_err = -100, we_hi = 0, err_cnt = 0;
    int r;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        else return a ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %h want %h", name, cyc, got, want);
        end
    endtask

    // Advance the model across the edge that ends cycle n.
    task automatic model_step(input int n);
        if (i_reset) begin
            occ_f = 1'b0; occ_d = 1'b0; act = 0; tmo = 1'b0;
            {e_ce_f, e_ce_d, e_we, e_iack, e_lack, e_err, e_busy} = 7'b0;
            e_addr = 16'h0000; e_dina = 16'h0000; e_instr = 16'h0000; e_rdata = 16'h0000;
        end else begin
            {e_ce_f, e_ce_d, e_we, e_iack, e_lack, e_err} = 6'b0;
            if (i_if_req && !occ_f) begin occ_f = 1'b1; f_addr = i_if_addr; end
            if (i_ls_req && !occ_d) begin
                occ_d = 1'b1; d_we = i_ls_we; d_addr = i_ls_addr; d_wdata = i_ls_wdata;
            end
            if (act != 0 && ack_at == n + 1) begin
                if (act == 1) begin
                    e_iack = 1'b1; e_instr = tmo ? 16'h0000 : mem_rd(f_addr); occ_f = 1'b0;
                end else begin
                    e_lack = 1'b1;
                    if (tmo) e_rdata = 16'h0000;
                    else if (!d_we) e_rdata = mem_rd(d_addr);
                    occ_d = 1'b0;
                end
                e_err = tmo;
                act = 0;
            end else if (act == 0 && (occ_d || occ_f)) begin
                ce_at = n + 1; act_lat = lat;
                tmo = !(lat >= 1 && lat <= P);
                ack_at = ce_at + (tmo ? P : lat) + 1;
                if (occ_d) begin
                    act = 2; e_ce_d = 1'b1; e_we = d_we; e_addr = d_addr;
                    if (d_we) begin e_dina = d_wdata; mem[int'(d_addr)] = d_wdata; end
                end else begin
                    act = 1; e_ce_f = 1'b1; e_addr = f_addr;
                end
            end
            e_busy = (act != 0);
        end
    endtask

    // Memory responder: completion strobe lat cycles after the ce.
    task automatic drive_resp();
        i_ce_dec = (act == 1) && !tmo && (cyc == ce_at + act_lat);
        i_ce_reg = (act == 2) && !tmo && (cyc == ce_at + act_lat);
        if (act == 1) i_mem_douta = mem_rd(f_addr);
        else if (act == 2 && !d_we) i_mem_douta = mem_rd(d_addr);
        else i_mem_douta = 16'hDEAD;
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_step(cyc);
        mvalid = 1'b1;
        cyc++;
        #1;
        i_if_req = 1'b0;
        i_ls_req = 1'b0;
        drive_resp();
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge i_clk);
            if (mvalid) begin
                chk("ce_fetch", {15'd0, q_ce_fetch}, {15'd0, e_ce_f});
                chk("ce_alu", {15'd0, q_ce_alu}, {15'd0, e_ce_d});
                chk("mem_we", {15'd0, q_mem_we}, {15'd0, e_we});
                chk("if_ack", {15'd0, q_if_ack}, {15'd0, e_iack});
                chk("ls_ack", {15'd0, q_ls_ack}, {15'd0, e_lack});
                chk("err", {15'd0, q_err}, {15'd0, e_err});
                chk("busy", {15'd0, q_busy}, {15'd0, e_busy});
                chk("if_instr", q_if_instr, e_instr);
                chk("ls_rdata", q_ls_rdata, e_rdata);
                if (e_ce_f || e_ce_d) chk("mem_addr", q_mem_addr, e_addr);
                if (e_ce_d && e_we) chk("mem_dina", q_mem_dina, e_dina);
                if (q_ce_fetch) last_cef = cyc;
                if (q_ce_alu) last_ced = cyc;
                if (q_if_ack) last_iack = cyc;
                if (q_ls_ack) last_lack = cyc;
                if (q_err) begin last_err = cyc; err_cnt++; end
                if (q_mem_we) we_hi++;
            end
        end
    end

    initial begin
        i_reset = 1'b1; i_if_req = 1'b0; i_if_addr = 16'h0000;
        i_ls_req = 1'b0; i_ls_we = 1'b0; i_ls_addr = 16'h0000; i_ls_wdata = 16'h0000;
        i_ce_dec = 1'b0; i_ce_reg = 1'b0; i_mem_douta = 16'h0000;
        mem[3] = 16'h2001;
        repeat (3) tick();
        chk("rst_instr", q_if_instr, 16'h0000);
        chk("rst_rdata", q_ls_rdata, 16'h0000);
        chk("rst_addr", q_mem_addr, 16'h0000);
        chk("rst_dina", q_mem_dina, 16'h0000);
        i_reset = 1'b0;
        tick();

        // fetch from 0x0003
        r = cyc; i_if_req = 1'b1; i_if_addr = 16'h0003; tick();
        repeat (5) tick();
        chk("fetch_ce_cycle", 16'(last_cef - r), 16'd1);
        chk("fetch_ack_cycle", 16'(last_iack - r), 16'd3);
        chk("fetch_instr", q_if_instr, 16'h2001);

        // store 0xCAFE to 0x00AA, then load it back
        r = cyc; i_ls_req = 1'b1; i_ls_we = 1'b1; i_ls_addr = 16'h00AA; i_ls_wdata = 16'hCAFE; tick();
        repeat (4) tick();
        chk("store_ack_cycle", 16'(last_lack - r), 16'd3);
        chk("store_keeps_rdata", q_ls_rdata, 16'h0000);
        i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 16'h00AA; i_ls_wdata = 16'h1111; tick();
        repeat (4) tick();
        chk("load_rdata", q_ls_rdata, 16'hCAFE);
        chk("we_cycles", 16'(we_hi), 16'd1);

        // collision: data first, fetch three cycles later
        r = cyc; i_if_req = 1'b1; i_if_addr = 16'h0020;
        i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 16'h0010; tick();
        repeat (8) tick();
        chk("coll_ce_alu", 16'(last_ced - r), 16'd1);
        chk("coll_ce_fetch", 16'(last_cef - r), 16'd4);
        chk("coll_ls_ack", 16'(last_lack - r), 16'd3);
        chk("coll_if_ack", 16'(last_iack - r), 16'd6);
        chk("coll_rdata", q_ls_rdata, 16'h5A4A);
        chk("coll_instr", q_if_instr, 16'h5A7A);

        // second request while pending is dropped; request in ack cycle is kept
        r = cyc; i_ls_req = 1'b1; i_ls_addr = 16'h0030; tick();
        i_ls_req = 1'b1; i_ls_addr = 16'h0040; tick();
        tick();
        i_ls_req = 1'b1; i_ls_addr = 16'h0050; tick();
        repeat (5) tick();
        chk("b2b_ack_cycle", 16'(last_lack - r), 16'd6);
        chk("b2b_rdata", q_ls_rdata, 16'h5A0A);

        // wrong-port strobe during FETCH, then strobes in IDLE
        r = cyc; lat = 3; i_if_req = 1'b1; i_if_addr = 16'h0060; tick();
        tick();
        i_ce_reg = 1'b1; tick();
        repeat (4) tick();
        chk("mismatch_ack_cycle", 16'(last_iack - r), 16'd5);
        chk("mismatch_instr", q_if_instr, 16'h5A3A);
        i_ce_dec = 1'b1; i_ce_reg = 1'b1; i_mem_douta = 16'hBEEF; tick();
        tick();

        // load timeout
        r = cyc; lat = 0; i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 16'h0070; tick();
        repeat (P + 4) tick();
        chk("tmo_ack_cycle", 16'(last_lack - r), 16'(P + 2));
        chk("tmo_err_cycle", 16'(last_err - r), 16'(P + 2));
        chk("tmo_rdata", q_ls_rdata, 16'h0000);

        // strobe exactly at the limit still completes without error
        r = cyc; lat = P; i_ls_req = 1'b1; i_ls_addr = 16'h0070; tick();
        repeat (P + 4) tick();
        chk("limit_ack_cycle", 16'(last_lack - r), 16'(P + 2));
        chk("limit_err_count", 16'(err_cnt), 16'd1);
        chk("limit_rdata", q_ls_rdata, 16'h5A2A);

        // fetch timeout
        r = cyc; lat = 0; i_if_req = 1'b1; i_if_addr = 16'h0080; tick();
        repeat (P + 4) tick();
        chk("ftmo_ack_cycle", 16'(last_iack - r), 16'(P + 2));
        chk("ftmo_instr", q_if_instr, 16'h0000);

        // reset during DATA, then a late completion strobe
        r = cyc; lat = 0; i_ls_req = 1'b1; i_ls_addr = 16'h0090; tick();
        repeat (3) tick();
        i_reset = 1'b1; tick();
        i_reset = 1'b0; i_ce_reg = 1'b1; i_mem_douta = 16'h1234; tick();
        repeat (3) tick();
        chk("rst_no_ack", {15'd0, last_lack < r}, 16'd1);
        chk("rst_busy", {15'd0, q_busy}, 16'd0);
        chk("rst_mid_rdata", q_ls_rdata, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prco_mem_ctrl.md
PRCO_MEM_CTRL -- requirements
Module: prco_mem_ctrl

Interface
REQ-001 SHALL have parameter P_TIMEOUT, default 15, meaning the cycles a request waits for a completion strobe before it is aborted.
REQ-002 SHALL have port i_clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port i_if_req  in  1  one-cycle instruction-fetch request strobe.
REQ-005 SHALL have port i_if_addr  in  16  fetch address, sampled with i_if_req.
REQ-006 SHALL have port q_if_ack  out  1  one-cycle pulse; fetch complete, q_if_instr valid.
REQ-007 SHALL have port q_if_instr  out  16  fetched word, held until the next fetch ack.
REQ-008 SHALL have port i_ls_req  in  1  one-cycle load/store request strobe.
REQ-009 SHALL have port i_ls_we  in  1  1 = store, 0 = load; sampled with i_ls_req.
REQ-010 SHALL have port i_ls_addr  in  16  data address, sampled with i_ls_req.
REQ-011 SHALL have port i_ls_wdata  in  16  store data, sampled with i_ls_req.
REQ-012 SHALL have port q_ls_ack  out  1  one-cycle pulse; load/store complete.
REQ-013 SHALL have port q_ls_rdata  out  16  load data, held until the next load/store ack.
REQ-014 SHALL have port q_ce_fetch  out  1  one-cycle memory enable for a fetch access.
REQ-015 SHALL have port q_ce_alu  out  1  one-cycle memory enable for a data access.
REQ-016 SHALL have port q_mem_we, q_mem_addr[16], q_mem_dina[16]  out  the memory write enable, address and write data, stable while any ce is high.
REQ-017 SHALL have ports i_ce_dec / i_ce_reg  in  1 each  memory completion strobes for a fetch / data access.
REQ-018 SHALL have port i_mem_douta  in  16  memory read data, valid while a completion strobe is high.
REQ-019 SHALL have port q_busy  out  1  high when the FSM is not in IDLE.
REQ-020 SHALL have port q_err  out  1  one-cycle pulse coincident with an ack that is caused by a timeout.

Function
REQ-021 SHALL keep one pending flag plus latched address per port (and we/wdata for the data port), set by that port's req strobe in any state.
REQ-022 SHALL ignore a req strobe while the same port's flag is already set; no overwrite of latched fields.
REQ-023 SHALL implement FSM states IDLE, FETCH and DATA.
REQ-024 SHALL, in IDLE with the data flag set, pulse q_ce_alu, drive the latched data fields and enter DATA; the data port has priority over the fetch port.
REQ-025 SHALL, in IDLE with only the fetch flag set, pulse q_ce_fetch with q_mem_we=0, drive the latched address and enter FETCH.
REQ-026 SHALL, in FETCH on i_ce_dec, register i_mem_douta into q_if_instr, pulse q_if_ack the next cycle, clear the fetch flag and return to IDLE.
REQ-027 SHALL, in DATA on i_ce_reg, register i_mem_douta into q_ls_rdata for loads only (stores leave it unchanged), pulse q_ls_ack, clear the data flag and return to IDLE.
REQ-028 SHALL ignore a completion strobe that does not match the current state, and any strobe seen in IDLE.
REQ-029 SHALL give a minimum latency of req strobe at cycle 0, ce at cycle 1, completion strobe at cycle 2, ack at cycle 3.
REQ-030 SHALL count cycles in FETCH/DATA from 0; on reaching P_TIMEOUT without a completion strobe, ack with data 16'h0000, pulse q_err, clear the flag and return to IDLE.
REQ-031 SHALL accept a req on a port in the same cycle as that port's ack as a new pending request.
REQ-032 SHALL start the next pending access in the cycle after return to IDLE; back-to-back throughput is one access per 3 cycles.
REQ-033 SHALL hold q_mem_we at 0 except during q_ce_alu of a store.

Reset
REQ-034 SHALL, while i_reset is high, enter IDLE, clear both flags and the timeout counter, and drive every output, including q_if_instr and q_ls_rdata, to 0.
REQ-035 SHALL abandon an in-flight access on reset with no ack, and ignore a late completion strobe after reset.

Verification
REQ-036 Fetch: i_if_req with addr 0x0003, memory returns 0x2001 -> q_ce_fetch at cycle 1, q_if_ack at cycle 3, q_if_instr=0x2001.
REQ-037 Store then load: store 0xCAFE to 0x00AA, then load 0x00AA -> q_mem_we=1 only on the store ce, q_ls_rdata=0xCAFE.
REQ-038 Collision: i_if_req and i_ls_req in the same cycle -> q_ce_alu first, q_ce_fetch 3 cycles later, both acked.
REQ-039 Timeout: load with no i_ce_reg -> q_ls_ack and q_err at cycle 1+P_TIMEOUT+1, q_ls_rdata=0x0000.
REQ-040 Reset mid-DATA, then i_ce_reg arrives -> no ack, all outputs 0, FSM in IDLE.
